psum_acc_row: RTL

- Upstream feeder for the softmax/normalisation row stage (sfp_row).
- Accumulates `num_acc` partial-sum rows of `col` signed lanes arriving from the array/ofifo path.
- Presents the finished row on `sfp_in` and drives that stage's `acc` strobe (sum phase), then its `div` strobe (divide phase) on request.
- Holds the row stable between the two phases, so the downstream stage sees identical data for both.

---
 rtl/psum_acc_row_pkg.sv | 29 ++
 rtl/psum_acc_row_lane_add.sv | 43 ++++
 rtl/psum_acc_row.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/psum_acc_row_pkg.sv
// Shared definitions for the partial-sum row accumulator.
//
// Holds:
//   - default geometry (lanes per row, lane widths, count width)
//   - the FSM state encoding
//   - saturation bounds for the default lane width
//
// Optional build macro: PSUM_SAT_EN. When it is defined, lane adds saturate
// to PSUM_MAX / PSUM_MIN instead of wrapping.
package psum_acc_row_pkg;

  localparam int COL     = 8;
  localparam int BW      = 8;
  localparam int BW_PSUM = 2 * BW + 4;
  localparam int CNT_BW  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    SUM   = 3'd2,
    HOLD  = 3'd3,
    DIV   = 3'd4
  } state_t;

  // Two's-complement limits of one lane at the default width.
  localparam logic [BW_PSUM-1:0] PSUM_MAX = {1'b0, {(BW_PSUM-1){1'b1}}};
  localparam logic [BW_PSUM-1:0] PSUM_MIN = {1'b1, {(BW_PSUM-1){1'b0}}};

endpackage

// File: rtl/psum_acc_row_lane_add.sv
// psum_lane_add: one signed lane adder of the row accumulator.
//
// Ports:
//   a, b   in   w  signed addends (running lane value, incoming partial)
//   sum    out  w  a + b
//   clamp  out  1  high when the result was clamped (PSUM_SAT_EN builds only)
//
// Build macro PSUM_SAT_EN:
//   - defined:   the add saturates to the most positive or most negative
//                w-bit value.
//   - undefined: the add wraps modulo 2^w.
module psum_lane_add
  import psum_acc_row_pkg::*;
#(
  parameter int w = BW_PSUM
) (
  input  logic signed [w-1:0] a,
  input  logic signed [w-1:0] b,
  output logic signed [w-1:0] sum
`ifdef PSUM_SAT_EN
  ,
  output logic                clamp
`endif
);

`ifdef PSUM_SAT_EN
  localparam logic signed [w-1:0] lane_max = {1'b0, {(w-1){1'b1}}};
  localparam logic signed [w-1:0] lane_min = {1'b1, {(w-1){1'b0}}};

  logic signed [w-1:0] raw;
  logic                ovf;

  assign raw = a + b;
  // Overflow is only possible when both operands have the same sign and the
  // wrapped result has the opposite sign.
  assign ovf   = (a[w-1] == b[w-1]) && (raw[w-1] != a[w-1]);
  assign sum   = ovf ? (a[w-1] ? lane_min : lane_max) : raw;
  assign clamp = ovf;
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/psum_acc_row.sv
// psum_acc_row: accumulates num_acc partial-sum rows and feeds sfp_row.
//
// The block sums the partial rows lane by lane. It then presents the
// finished row on sfp_in and pulses acc (sum phase). It holds the row
// stable until div_req arrives, and then pulses div and done together
// (divide phase).
//
// Ports:
//   clk       in   1            clock, all state on the rising edge
//   reset     in   1            asynchronous active-high clear
//   start     in   1            begin a row (sampled only in IDLE)
//   num_acc   in   cnt_bw       partials per row, 0 treated as 1
//   in_valid  in   1            partial row valid
//   in_ready  out  1            partial accepted (high only in ACCUM)
//   in_data   in   col*bw_psum  partial row, lane i at [bw_psum*i +: bw_psum]
//   div_req   in   1            request divide phase (sampled only in HOLD)
//   sfp_in    out  col*bw_psum  registered accumulated row
//   acc       out  1            sum-phase strobe
//   div       out  1            divide-phase strobe
//   busy      out  1            not IDLE
//   done      out  1            row finished, coincident with div
//   sat       out  1            sticky clamp flag (PSUM_SAT_EN builds only)
//
// Build macro PSUM_SAT_EN:
//   - defined:   saturating lane adds and a sat output.
//   - undefined: wrapping lane adds and no sat port.
module psum_acc_row
  import psum_acc_row_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw      = BW,
  parameter int bw_psum = 2 * bw + 4,
  parameter int cnt_bw  = CNT_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [cnt_bw-1:0]      num_acc,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*bw_psum-1:0] in_data,
  input  logic                   div_req,
  output logic [col*bw_psum-1:0] sfp_in,
  output logic                   acc,
  output logic                   div,
  output logic                   busy,
  output logic                   done
`ifdef PSUM_SAT_EN
  ,
  output logic                   sat
`endif
);

  state_t                 state, state_nx;
  logic [cnt_bw-1:0]      beat_cnt;
  logic [cnt_bw-1:0]      cnt_lat;
  logic [cnt_bw-1:0]      beat_nx;
  logic                   beat_ok;
  logic                   last_beat;
  logic [col*bw_psum-1:0] lane_sum;
`ifdef PSUM_SAT_EN
  logic [col-1:0]         lane_clamp;
`endif

  // One lane adder per lane. Each adder adds the incoming partial to the
  // registered running value.
  for (genvar g = 0; g < col; g++) begin : g_lane
    psum_lane_add #(.w(bw_psum)) u_add (
      .a     (sfp_in[g*bw_psum +: bw_psum]),
      .b     (in_data[g*bw_psum +: bw_psum]),
      .sum   (lane_sum[g*bw_psum +: bw_psum])
`ifdef PSUM_SAT_EN
      ,
      .clamp (lane_clamp[g])
`endif
    );
  end

  assign beat_ok   = in_valid && (state == ACCUM);
  assign beat_nx   = beat_cnt + cnt_bw'(1);
  assign last_beat = beat_ok && (beat_nx == cnt_lat);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples its pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The accumulator, beat counter and latched count change only on an
  // accepted start (clear) or on an accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sfp_in   <= '0;
      beat_cnt <= '0;
      cnt_lat  <= '0;
`ifdef PSUM_SAT_EN
      sat      <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      sfp_in   <= '0;
      beat_cnt <= '0;
      cnt_lat  <= (num_acc == '0) ? cnt_bw'(1) : num_acc;
`ifdef PSUM_SAT_EN
      sat      <= 1'b0;
`endif
    end else if (beat_ok) begin
      sfp_in   <= lane_sum;
      beat_cnt <= beat_nx;
`ifdef PSUM_SAT_EN
      sat      <= sat | (|lane_clamp);
`endif
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    acc      = 1'b0;
    div      = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (last_beat) state_nx = SUM;
      end
      SUM: begin
        acc      = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (div_req) state_nx = DIV;
      end
      DIV: begin
        div      = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
